// File: rtl/mult_issue_ctrl.sv
// ============================================================================
// mult_issue_ctrl - two-port issue arbiter and in-order result return for the
// shared pipelined multiplier. Optional macro: MULT_ARB_RR_EN (round robin).
// Revision: 1.0
// ============================================================================
`default_nettype none

module mult_issue_ctrl #(
   parameter int MAX_INFLIGHT = 4,
   parameter int TAG_W        = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             REQ0_VALID_SD,
   output logic             REQ0_READY_SD,
   input  logic [31:0]      REQ0_OP1_SD,
   input  logic [31:0]      REQ0_OP2_SD,
   input  logic [1:0]       REQ0_CMD_SD,
   input  logic [TAG_W-1:0] REQ0_TAG_SD,
   input  logic             REQ1_VALID_SD,
   output logic             REQ1_READY_SD,
   input  logic [31:0]      REQ1_OP1_SD,
   input  logic [31:0]      REQ1_OP2_SD,
   input  logic [1:0]       REQ1_CMD_SD,
   input  logic [TAG_W-1:0] REQ1_TAG_SD,
   output logic             MUL_VALID_SX,
   input  logic             MUL_READY_SX,
   output logic [31:0]      MUL_OP1_SX,
   output logic [31:0]      MUL_OP2_SX,
   output logic [1:0]       MUL_CMD_SX,
   input  logic             MUL_RES_VALID_SX,
   input  logic [31:0]      MUL_RES_SX,
   output logic             MUL_RES_POP_SX,
   input  logic             FLUSH_SX,
   output logic             RES_VALID_SX,
   input  logic             RES_READY_SX,
   output logic             RES_SRC_SX,
   output logic [TAG_W-1:0] RES_TAG_SX,
   output logic [31:0]      RES_DATA_SX,
   output logic             ERR_SX
);

   localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
   localparam int PTR_W = $clog2(MAX_INFLIGHT);
   localparam logic [CNT_W-1:0] c_max      = CNT_W'(MAX_INFLIGHT);
   localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
   localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(MAX_INFLIGHT - 1);
   localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);

   logic [CNT_W-1:0] r_inflight;
   logic [CNT_W-1:0] r_kill;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic             r_err;
   logic             r_meta_src [MAX_INFLIGHT];
   logic [TAG_W-1:0] r_meta_tag [MAX_INFLIGHT];

   logic w_any_req;
   logic w_winner;
   logic w_can_issue;
   logic w_issue;
   logic w_kill_nz;
   logic w_discard;
   logic w_pop;
   logic w_err;
   logic [TAG_W-1:0] w_win_tag;

   assign w_any_req = REQ0_VALID_SD | REQ1_VALID_SD;

`ifdef MULT_ARB_RR_EN
   logic r_last;
   // Port 1 wins when alone, or when both request and port 0 won last time.
   assign w_winner = REQ1_VALID_SD & (~REQ0_VALID_SD | ~r_last);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_last <= 1'b1;
      else if (w_issue)
         r_last <= w_winner;
   end
`else
   assign w_winner = REQ1_VALID_SD & ~REQ0_VALID_SD;
`endif

   // Credit check uses the registered count only, keeping RES_READY off the issue path.
   assign w_can_issue   = (r_inflight < c_max) & ~FLUSH_SX;
   assign MUL_VALID_SX  = w_can_issue & w_any_req;
   assign w_issue       = MUL_VALID_SX & MUL_READY_SX;
   assign REQ0_READY_SD = w_issue & ~w_winner;
   assign REQ1_READY_SD = w_issue & w_winner;
   assign w_win_tag     = w_winner ? REQ1_TAG_SD : REQ0_TAG_SD;

   always_comb begin
      MUL_OP1_SX = 32'd0;
      MUL_OP2_SX = 32'd0;
      MUL_CMD_SX = 2'd0;
      if (MUL_VALID_SX) begin
         MUL_OP1_SX = w_winner ? REQ1_OP1_SD : REQ0_OP1_SD;
         MUL_OP2_SX = w_winner ? REQ1_OP2_SD : REQ0_OP2_SD;
         MUL_CMD_SX = w_winner ? REQ1_CMD_SD : REQ0_CMD_SD;
      end
   end

   assign w_kill_nz      = (r_kill != '0);
   assign w_discard      = MUL_RES_VALID_SX & w_kill_nz;
   assign RES_VALID_SX   = MUL_RES_VALID_SX & ~w_kill_nz & (r_inflight != '0);
   assign w_pop          = w_discard | (RES_VALID_SX & RES_READY_SX);
   assign MUL_RES_POP_SX = w_pop;
   assign w_err          = MUL_RES_VALID_SX & (r_inflight == '0);

   assign RES_SRC_SX  = RES_VALID_SX & r_meta_src[r_rd_ptr];
   assign RES_TAG_SX  = RES_VALID_SX ? r_meta_tag[r_rd_ptr] : '0;
   assign RES_DATA_SX = RES_VALID_SX ? MUL_RES_SX : 32'd0;
   assign ERR_SX      = r_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_inflight <= '0;
         r_kill     <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_err      <= 1'b0;
      end else begin
         case ({w_issue, w_pop})
            2'b10:   r_inflight <= r_inflight + c_cnt_one;
            2'b01:   r_inflight <= r_inflight - c_cnt_one;
            default: r_inflight <= r_inflight;
         endcase
         // Everything not popped this cycle belongs to the flushed window.
         if (FLUSH_SX)
            r_kill <= r_inflight - {{(CNT_W-1){1'b0}}, w_pop};
         else if (w_discard)
            r_kill <= r_kill - c_cnt_one;
         if (w_issue)
            r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_ptr_one;
         if (w_pop)
            r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_ptr_one;
         if (w_err)
            r_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_issue) begin
         r_meta_src[r_wr_ptr] <= w_winner;
         r_meta_tag[r_wr_ptr] <= w_win_tag;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mult_issue_ctrl.sv
// Scoreboard bench for mult_issue_ctrl: directed stimulus queues expected
// issues/results, a negedge monitor pops and compares them.
`default_nettype none

module tb_mult_issue_ctrl;
   localparam int TAG_W = 5;

   logic clk = 1'b0;
   logic reset;
   logic REQ0_VALID_SD, REQ0_READY_SD, REQ1_VALID_SD, REQ1_READY_SD;
   logic [31:0] REQ0_OP1_SD, REQ0_OP2_SD, REQ1_OP1_SD, REQ1_OP2_SD;
   logic [1:0]  REQ0_CMD_SD, REQ1_CMD_SD;
   logic [TAG_W-1:0] REQ0_TAG_SD, REQ1_TAG_SD;
   logic MUL_VALID_SX, MUL_READY_SX;
   logic [31:0] MUL_OP1_SX, MUL_OP2_SX;
   logic [1:0]  MUL_CMD_SX;
   logic MUL_RES_VALID_SX, MUL_RES_POP_SX, FLUSH_SX;
   logic [31:0] MUL_RES_SX;
   logic RES_VALID_SX, RES_READY_SX, RES_SRC_SX, ERR_SX;
   logic [TAG_W-1:0] RES_TAG_SX;
   logic [31:0] RES_DATA_SX;

   typedef struct packed {
      logic        src;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [1:0]  cmd;
   } iss_t;

   typedef struct packed {
      logic             src;
      logic [TAG_W-1:0] tag;
      logic [31:0]      data;
   } res_t;

   iss_t iss_q[$];
   res_t res_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   mult_issue_ctrl #(.MAX_INFLIGHT(4), .TAG_W(TAG_W)) dut (
      .clk(clk), .reset(reset),
      .REQ0_VALID_SD(REQ0_VALID_SD), .REQ0_READY_SD(REQ0_READY_SD),
      .REQ0_OP1_SD(REQ0_OP1_SD), .REQ0_OP2_SD(REQ0_OP2_SD),
      .REQ0_CMD_SD(REQ0_CMD_SD), .REQ0_TAG_SD(REQ0_TAG_SD),
      .REQ1_VALID_SD(REQ1_VALID_SD), .REQ1_READY_SD(REQ1_READY_SD),
      .REQ1_OP1_SD(REQ1_OP1_SD), .REQ1_OP2_SD(REQ1_OP2_SD),
      .REQ1_CMD_SD(REQ1_CMD_SD), .REQ1_TAG_SD(REQ1_TAG_SD),
      .MUL_VALID_SX(MUL_VALID_SX), .MUL_READY_SX(MUL_READY_SX),
      .MUL_OP1_SX(MUL_OP1_SX), .MUL_OP2_SX(MUL_OP2_SX), .MUL_CMD_SX(MUL_CMD_SX),
      .MUL_RES_VALID_SX(MUL_RES_VALID_SX), .MUL_RES_SX(MUL_RES_SX),
      .MUL_RES_POP_SX(MUL_RES_POP_SX), .FLUSH_SX(FLUSH_SX),
      .RES_VALID_SX(RES_VALID_SX), .RES_READY_SX(RES_READY_SX),
      .RES_SRC_SX(RES_SRC_SX), .RES_TAG_SX(RES_TAG_SX), .RES_DATA_SX(RES_DATA_SX),
      .ERR_SX(ERR_SX)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clr();
      REQ0_VALID_SD = 0; REQ0_OP1_SD = 0; REQ0_OP2_SD = 0; REQ0_CMD_SD = 0; REQ0_TAG_SD = 0;
      REQ1_VALID_SD = 0; REQ1_OP1_SD = 0; REQ1_OP2_SD = 0; REQ1_CMD_SD = 0; REQ1_TAG_SD = 0;
      MUL_READY_SX = 1; MUL_RES_VALID_SX = 0; MUL_RES_SX = 0; FLUSH_SX = 0; RES_READY_SX = 1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req0(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c,
                       input logic [TAG_W-1:0] t);
      REQ0_VALID_SD = 1; REQ0_OP1_SD = a; REQ0_OP2_SD = b; REQ0_CMD_SD = c; REQ0_TAG_SD = t;
   endtask

   task automatic exp_iss(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] c);
      iss_t e;
      e.src = s; e.op1 = a; e.op2 = b; e.cmd = c;
      iss_q.push_back(e);
   endtask

   task automatic exp_res(input logic s, input logic [TAG_W-1:0] t, input logic [31:0] d);
      res_t e;
      e.src = s; e.tag = t; e.data = d;
      res_q.push_back(e);
   endtask

   task automatic ret(input logic [31:0] d);
      MUL_RES_VALID_SX = 1; MUL_RES_SX = d;
   endtask

   function automatic logic any_out();
      return |{MUL_VALID_SX, REQ0_READY_SD, REQ1_READY_SD, MUL_OP1_SX, MUL_OP2_SX, MUL_CMD_SX,
               MUL_RES_POP_SX, RES_VALID_SX, RES_SRC_SX, RES_TAG_SX, RES_DATA_SX, ERR_SX};
   endfunction

   // Monitor: compares every issue and every accepted result against the queues.
   always @(negedge clk) begin
      if (!reset) begin
         if (MUL_VALID_SX && MUL_READY_SX) begin
            n_tests++;
            if (iss_q.size() == 0) begin
               n_fail++;
               $display("FAIL issue_unexpected: got op1=%0h op2=%0h expected none", MUL_OP1_SX, MUL_OP2_SX);
            end else begin
               iss_t e;
               iss_t a;
               e = iss_q.pop_front();
               a.src = REQ1_READY_SD; a.op1 = MUL_OP1_SX; a.op2 = MUL_OP2_SX; a.cmd = MUL_CMD_SX;
               if (a !== e) begin
                  n_fail++;
                  $display("FAIL issue: got %0h expected %0h", a, e);
               end
            end
         end else if (!MUL_VALID_SX) begin
            n_tests++;
            if ({MUL_OP1_SX, MUL_OP2_SX, MUL_CMD_SX} !== '0) begin
               n_fail++;
               $display("FAIL issue_idle_zero: got %0h expected 0", {MUL_OP1_SX, MUL_OP2_SX, MUL_CMD_SX});
            end
         end
         if (RES_VALID_SX && RES_READY_SX) begin
            n_tests++;
            if (res_q.size() == 0) begin
               n_fail++;
               $display("FAIL result_unexpected: got data=%0h expected none", RES_DATA_SX);
            end else begin
               res_t e;
               res_t a;
               e = res_q.pop_front();
               a.src = RES_SRC_SX; a.tag = RES_TAG_SX; a.data = RES_DATA_SX;
               if (a !== e) begin
                  n_fail++;
                  $display("FAIL result: got src=%0d tag=%0d data=%0h expected src=%0d tag=%0d data=%0h",
                           a.src, a.tag, a.data, e.src, e.tag, e.data);
               end
            end
         end else if (!RES_VALID_SX) begin
            n_tests++;
            if ({RES_SRC_SX, RES_TAG_SX, RES_DATA_SX} !== '0) begin
               n_fail++;
               $display("FAIL result_idle_zero: got %0h expected 0", {RES_SRC_SX, RES_TAG_SX, RES_DATA_SX});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic w_arr [4];
      clr();
      reset = 1;
      tick();
      tick();
      chk("reset_outputs", {63'd0, any_out()}, 64'd0);
      reset = 0;
      tick();

      // Contention straight after reset: round robin alternates from port 0.
      req0(2, 3, 2'd0, 5'd1);
      REQ1_VALID_SD = 1; REQ1_OP1_SD = 4; REQ1_OP2_SD = 5; REQ1_CMD_SD = 2'd3; REQ1_TAG_SD = 5'd2;
      for (int i = 0; i < 4; i++) begin
`ifdef MULT_ARB_RR_EN
         w_arr[i] = (i % 2) == 1;
`else
         w_arr[i] = 1'b0;
`endif
         if (w_arr[i]) exp_iss(1'b1, 4, 5, 2'd3);
         else          exp_iss(1'b0, 2, 3, 2'd0);
         @(negedge clk);
         chk("contend_ready0", {63'd0, REQ0_READY_SD}, {63'd0, !w_arr[i]});
         chk("contend_ready1", {63'd0, REQ1_READY_SD}, {63'd0, w_arr[i]});
         tick();
      end
      clr();
      for (int i = 0; i < 4; i++) begin
         ret(100 + i);
         exp_res(w_arr[i], w_arr[i] ? 5'd2 : 5'd1, 100 + i);
         @(negedge clk);
         chk("contend_ret_pop", {63'd0, MUL_RES_POP_SX}, 64'd1);
         tick();
      end
      clr();

      // Single requester: 3*3, tag 5.
      req0(3, 3, 2'd0, 5'd5);
      exp_iss(1'b0, 3, 3, 2'd0);
      @(negedge clk);
      chk("single_ready", {63'd0, REQ0_READY_SD}, 64'd1);
      tick();
      clr();
      ret(9);
      exp_res(1'b0, 5'd5, 9);
      @(negedge clk);
      chk("single_res_valid", {63'd0, RES_VALID_SX}, 64'd1);
      tick();
      clr();

      // Credit full: four issues, fifth blocked even with a same-cycle pop.
      for (int i = 0; i < 4; i++) begin
         req0(i + 1, 2, 2'd1, 5'(10 + i));
         exp_iss(1'b0, i + 1, 2, 2'd1);
         @(negedge clk);
         chk("credit_fill_ready", {63'd0, REQ0_READY_SD}, 64'd1);
         tick();
      end
      req0(7, 7, 2'd2, 5'd14);
      ret(200);
      exp_res(1'b0, 5'd10, 200);
      @(negedge clk);
      chk("credit_full_ready", {63'd0, REQ0_READY_SD}, 64'd0);
      chk("credit_full_valid", {63'd0, MUL_VALID_SX}, 64'd0);
      chk("credit_full_pop", {63'd0, MUL_RES_POP_SX}, 64'd1);
      tick();
      MUL_RES_VALID_SX = 0;
      exp_iss(1'b0, 7, 7, 2'd2);
      @(negedge clk);
      chk("credit_reenable", {63'd0, REQ0_READY_SD}, 64'd1);
      tick();
      clr();
      for (int i = 0; i < 4; i++) begin
         ret(201 + i);
         exp_res(1'b0, 5'(11 + i), 201 + i);
         tick();
      end
      clr();

      // Flush with three in flight and no return that cycle.
      for (int i = 0; i < 3; i++) begin
         req0(i, 10, 2'd3, 5'(20 + i));
         exp_iss(1'b0, i, 10, 2'd3);
         tick();
      end
      req0(9, 9, 2'd0, 5'd23);
      FLUSH_SX = 1;
      @(negedge clk);
      chk("flush_ready", {63'd0, REQ0_READY_SD}, 64'd0);
      chk("flush_mul_valid", {63'd0, MUL_VALID_SX}, 64'd0);
      tick();
      clr();
      for (int i = 0; i < 3; i++) begin
         ret(300 + i);
         @(negedge clk);
         chk("flush_discard_valid", {63'd0, RES_VALID_SX}, 64'd0);
         chk("flush_discard_pop", {63'd0, MUL_RES_POP_SX}, 64'd1);
         tick();
      end
      clr();
      req0(6, 7, 2'd0, 5'd24);
      exp_iss(1'b0, 6, 7, 2'd0);
      tick();
      clr();
      ret(42);
      exp_res(1'b0, 5'd24, 42);
      @(negedge clk);
      chk("post_flush_valid", {63'd0, RES_VALID_SX}, 64'd1);
      tick();
      clr();

      // Flush and delivered pop in the same cycle.
      req0(5, 5, 2'd0, 5'd30);
      exp_iss(1'b0, 5, 5, 2'd0);
      tick();
      req0(6, 6, 2'd0, 5'd31);
      exp_iss(1'b0, 6, 6, 2'd0);
      tick();
      clr();
      FLUSH_SX = 1;
      ret(55);
      exp_res(1'b0, 5'd30, 55);
      @(negedge clk);
      chk("flushpop_valid", {63'd0, RES_VALID_SX}, 64'd1);
      tick();
      clr();
      ret(56);
      @(negedge clk);
      chk("flushpop_kill_valid", {63'd0, RES_VALID_SX}, 64'd0);
      chk("flushpop_kill_pop", {63'd0, MUL_RES_POP_SX}, 64'd1);
      tick();
      clr();

      // Protocol error: result with nothing in flight.
      ret(1);
      @(negedge clk);
      chk("err_no_pop", {63'd0, MUL_RES_POP_SX}, 64'd0);
      chk("err_no_valid", {63'd0, RES_VALID_SX}, 64'd0);
      tick();
      clr();
      @(negedge clk);
      chk("err_set", {63'd0, ERR_SX}, 64'd1);
      tick();
      tick();
      @(negedge clk);
      chk("err_sticky", {63'd0, ERR_SX}, 64'd1);
      tick();

      // Reset mid-operation with one op in flight.
      req0(2, 2, 2'd0, 5'd9);
      exp_iss(1'b0, 2, 2, 2'd0);
      tick();
      clr();
      #2 reset = 1;
      #1;
      chk("midreset_outputs", {63'd0, any_out()}, 64'd0);
      chk("midreset_err", {63'd0, ERR_SX}, 64'd0);
      tick();
      reset = 0;
      req0(6, 7, 2'd0, 5'd7);
      exp_iss(1'b0, 6, 7, 2'd0);
      tick();
      clr();
      ret(42);
      exp_res(1'b0, 5'd7, 42);
      @(negedge clk);
      chk("post_reset_valid", {63'd0, RES_VALID_SX}, 64'd1);
      tick();
      clr();
      tick();

      chk("iss_queue_empty", 64'(iss_q.size()), 64'd0);
      chk("res_queue_empty", 64'(res_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
